// File: rtl/reg_intf.sv
// Register-interface bus types shared by bus masters and slaves.
package reg_intf;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_intf_req_a32_d32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_intf_resp_d32;

endpackage

// File: rtl/plic_claim_engine.sv
// PLIC claim engine for one target context.
// On a pending external interrupt it reads the claim/complete register,
// hands the claimed ID to a local consumer, waits for the consumer to
// finish, then writes the same ID back as the completion.
module plic_claim_engine #(
  parameter int unsigned N_SOURCE  = 30,
  parameter int unsigned SRCW      = $clog2(N_SOURCE + 1),
  parameter logic [31:0] PLIC_BASE = 32'h0C00_0000,
  parameter int unsigned TARGET_ID = 0,
  parameter logic [31:0] CC_ADDR   = PLIC_BASE + 32'h0020_0004 + TARGET_ID * 32'h1000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         eip_i,
  output reg_intf::reg_intf_req_a32_d32 req_o,
  input  reg_intf::reg_intf_resp_d32    resp_i,
  output logic                         irq_valid_o,
  output logic [SRCW-1:0]              irq_id_o,
  input  logic                         irq_ready_i,
  input  logic                         done_valid_i,
  output logic                         done_ready_o,
  output logic                         busy_o,
  output logic                         err_o,
  output logic [15:0]                  spurious_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    CLAIM,
    DISPATCH,
    WAIT_DONE,
    COMPLETE
  } state_e;

  state_e          state_q;
  logic [SRCW-1:0] id_q;
  logic [15:0]     spurious_q;
  logic            req_valid_q;
  logic            req_write_q;
  logic            irq_valid_q;
  logic            done_ready_q;
  logic            err_q;

  // Claim/dispatch/complete sequencer; all handshake outputs are registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      id_q         <= '0;
      spurious_q   <= '0;
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      irq_valid_q  <= 1'b0;
      done_ready_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i && eip_i) begin
            state_q     <= CLAIM;
            req_valid_q <= 1'b1;
            req_write_q <= 1'b0;
          end
        end
        CLAIM: begin
          if (resp_i.ready) begin
            req_valid_q <= 1'b0;
            state_q     <= IDLE;
            if (resp_i.error) begin
              err_q <= 1'b1;
            end else if (resp_i.rdata == '0) begin
              if (spurious_q != 16'hFFFF) begin
                spurious_q <= spurious_q + 16'd1;
              end
            end else if (resp_i.rdata > N_SOURCE) begin
              err_q <= 1'b1;
            end else begin
              id_q        <= resp_i.rdata[SRCW-1:0];
              irq_valid_q <= 1'b1;
              state_q     <= DISPATCH;
            end
          end
        end
        DISPATCH: begin
          if (irq_ready_i) begin
            irq_valid_q  <= 1'b0;
            done_ready_q <= 1'b1;
            state_q      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done_valid_i) begin
            done_ready_q <= 1'b0;
            req_valid_q  <= 1'b1;
            req_write_q  <= 1'b1;
            state_q      <= COMPLETE;
          end
        end
        COMPLETE: begin
          if (resp_i.ready) begin
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            err_q       <= resp_i.error;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Bus request fields are derived from the registered request state so they
  // stay stable for as long as valid is held.
  always_comb begin
    req_o       = '0;
    req_o.addr  = CC_ADDR;
    req_o.write = req_write_q;
    req_o.wdata = req_write_q ? 32'(id_q) : '0;
    req_o.wstrb = req_write_q ? 4'hF : 4'h0;
    req_o.valid = req_valid_q;
  end

  assign irq_valid_o    = irq_valid_q;
  assign irq_id_o       = id_q;
  assign done_ready_o   = done_ready_q;
  assign busy_o         = (state_q != IDLE);
  assign err_o          = err_q;
  assign spurious_cnt_o = spurious_q;

endmodule
